multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 252 +++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// ============================================================================
// multicycle_ctrl
// ----------------------------------------------------------------------------
// Multicycle instruction-sequencing controller. The controller fetches one
// instruction word and runs it for one cycle (EXEC) or for MEM_LAT cycles
// (MEM, loads and stores only). It then returns to FETCH. Opcode 13 halts
// the sequence until Start is seen again.
//
// All strobes come from registers. Each cycle they are decoded from the
// state and IR that the controller moves into on the next edge, so they line
// up with that state without any combinational path from Instruction or
// Instr_valid. The only combinational input-to-output path is ZERO ->
// branch_taken. A conditional branch must see the ALU result of its own EXEC
// cycle.
//
// Parameters
//   IW       instruction width (>= 6); bit IW-1 = branch flag,
//            bits IW-2:IW-5 = opcode
//   MEM_LAT  cycles a load/store stays in MEM (1..15)
//
// Optional feature (macro CTRL_INSTR_COUNT_EN)
//   Adds output instr_count[15:0]. It counts pc_advance pulses and wraps
//   at 16 bits.
//
// Ports
//   Clk           single clock, rising edge
//   Reset_n       asynchronous active-low reset
//   Start         leaves IDLE/HALT and begins fetching
//   Instruction   instruction word from ROM
//   Instr_valid   Instruction is valid this cycle
//   ZERO          ALU result is zero
//   MEM_READ, MEM_WRITE, REG_WRITE, ACC_WRITE, IS_MEM   strobes
//   lookup[2:0]   one-hot table select (bit0 LOOKUP, bit1 LOOKUP2,
//                 bit2 LOOKUP3)
//   branch, branch_taken, pc_advance, busy, done
//   instr_count   (CTRL_INSTR_COUNT_EN only) retired-instruction counter
//
// State  | meaning
// -------+---------------------------------------------------------------
// IDLE   | after reset; waits for Start
// FETCH  | waits for Instr_valid, latches IR, picks EXEC or MEM
// EXEC   | single-cycle execute; opcode 13 goes on to HALT
// MEM    | load/store held for MEM_LAT cycles by mem_cnt
// HALT   | done=1; waits for Start to resume fetching
// ============================================================================
module multicycle_ctrl #(
    parameter int IW      = 9,
    parameter int MEM_LAT = 1
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          Start,
    input  logic [IW-1:0] Instruction,
    input  logic          Instr_valid,
    input  logic          ZERO,
    output logic          MEM_READ,
    output logic          MEM_WRITE,
    output logic          REG_WRITE,
    output logic          ACC_WRITE,
    output logic          IS_MEM,
    output logic [2:0]    lookup,
    output logic          branch,
    output logic          branch_taken,
    output logic          pc_advance,
    output logic          busy,
    output logic          done
`ifdef CTRL_INSTR_COUNT_EN
    ,
    output logic [15:0]   instr_count
`endif
);

    localparam logic [3:0] OP_LUT3  = 4'd2;
    localparam logic [3:0] OP_LUT2  = 4'd3;
    localparam logic [3:0] OP_REGW  = 4'd9;
    localparam logic [3:0] OP_LOAD  = 4'd11;
    localparam logic [3:0] OP_STORE = 4'd12;
    localparam logic [3:0] OP_HALT  = 4'd13;
    localparam logic [3:0] OP_LUT1  = 4'd14;

    localparam logic [3:0] MEM_LAT_CNT = 4'(MEM_LAT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_HALT
    } state_t;

    // br_cond marks a conditional branch. branch_taken then follows ZERO
    // live instead of coming from a stored value.
    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       acc_write;
        logic       is_mem;
        logic [2:0] lookup;
        logic       branch;
        logic       taken;
        logic       br_cond;
        logic       pc_advance;
        logic       busy;
        logic       done;
    } strobe_t;

    state_t        state;
    state_t        nxt_state;
    logic [IW-1:0] ir;
    logic [IW-1:0] nxt_ir;
    logic [3:0]    mem_cnt;
    logic [3:0]    nxt_cnt;
    strobe_t       dec;
    strobe_t       out_r;

    logic [3:0]    in_op;
    logic [3:0]    ir_op;
    logic [3:0]    nxt_op;
    logic          ir_unused;

    assign in_op  = Instruction[IW-2 -: 4];
    assign ir_op  = ir[IW-2 -: 4];
    assign nxt_op = nxt_ir[IW-2 -: 4];

    // The low IR bits are operand fields that belong to the datapath.
    assign ir_unused = ^ir;

    always_comb begin
        nxt_state = state;
        nxt_ir    = ir;
        nxt_cnt   = mem_cnt;
        unique case (state)
            S_IDLE, S_HALT: begin
                if (Start) nxt_state = S_FETCH;
            end
            S_FETCH: begin
                if (Instr_valid) begin
                    nxt_ir = Instruction;
                    if (!Instruction[IW-1] &&
                        (in_op == OP_LOAD || in_op == OP_STORE)) begin
                        nxt_state = S_MEM;
                        nxt_cnt   = MEM_LAT_CNT;
                    end else begin
                        nxt_state = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                nxt_state = (ir_op == OP_HALT) ? S_HALT : S_FETCH;
            end
            S_MEM: begin
                if (mem_cnt <= 4'd1) begin
                    nxt_state = S_FETCH;
                    nxt_cnt   = 4'd0;
                end else begin
                    nxt_cnt = mem_cnt - 4'd1;
                end
            end
            default: begin
                nxt_state = S_IDLE;
            end
        endcase
    end

    // Strobes for the state being entered. The final MEM cycle is the one
    // that enters MEM with a count of 1.
    always_comb begin
        dec = '0;
        unique case (nxt_state)
            S_FETCH: dec.busy = 1'b1;
            S_HALT:  dec.done = 1'b1;
            S_EXEC: begin
                dec.busy       = 1'b1;
                dec.pc_advance = (nxt_op != OP_HALT);
                if (nxt_ir[IW-1]) begin
                    dec.branch  = 1'b1;
                    dec.br_cond = 1'b1;
                end else begin
                    unique case (nxt_op)
                        OP_LUT3: begin
                            dec.lookup = 3'b100;
                            dec.branch = 1'b1;
                            dec.taken  = 1'b1;
                        end
                        OP_LUT2: begin
                            dec.lookup = 3'b010;
                            dec.branch = 1'b1;
                            dec.taken  = 1'b1;
                        end
                        OP_REGW: dec.reg_write = 1'b1;
                        OP_LUT1: begin
                            dec.lookup    = 3'b001;
                            dec.acc_write = 1'b1;
                        end
                        OP_LOAD, OP_STORE, OP_HALT: ;
                        default: dec.acc_write = 1'b1;
                    endcase
                end
            end
            S_MEM: begin
                dec.busy       = 1'b1;
                dec.pc_advance = (nxt_cnt == 4'd1);
                if (nxt_op == OP_LOAD) begin
                    dec.mem_read  = 1'b1;
                    dec.is_mem    = 1'b1;
                    dec.acc_write = (nxt_cnt == 4'd1);
                end else begin
                    dec.mem_write = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state   <= S_IDLE;
            ir      <= '0;
            mem_cnt <= 4'd0;
            out_r   <= '0;
        end else begin
            state   <= nxt_state;
            ir      <= nxt_ir;
            mem_cnt <= nxt_cnt;
            out_r   <= dec;
        end
    end

`ifdef CTRL_INSTR_COUNT_EN
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            instr_count <= 16'h0000;
        end else if (out_r.pc_advance) begin
            instr_count <= instr_count + 16'h0001;
        end
    end
`endif

    assign MEM_READ     = out_r.mem_read;
    assign MEM_WRITE    = out_r.mem_write;
    assign REG_WRITE    = out_r.reg_write;
    assign ACC_WRITE    = out_r.acc_write;
    assign IS_MEM       = out_r.is_mem;
    assign lookup       = out_r.lookup;
    assign branch       = out_r.branch;
    assign branch_taken = out_r.taken | (out_r.br_cond & ZERO);
    assign pc_advance   = out_r.pc_advance;
    assign busy         = out_r.busy;
    assign done         = out_r.done;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ============================================================================
// tb_multicycle_ctrl
// ----------------------------------------------------------------------------
// Scoreboard bench for multicycle_ctrl with IW=9 and MEM_LAT=3. For each
// instruction, the expected per-cycle output vector is pushed when the
// instruction is driven. The vectors are popped and compared as the DUT
// steps through EXEC/MEM and back to FETCH or HALT.
// Vector layout: {MEM_READ, MEM_WRITE, REG_WRITE, ACC_WRITE, IS_MEM,
//                 lookup[2:0], branch, branch_taken, pc_advance, busy, done}
// ============================================================================
module tb_multicycle_ctrl;

    localparam int IW      = 9;
    localparam int MEM_LAT = 3;

    localparam logic [12:0] V_IDLE  = 13'h0000;
    localparam logic [12:0] V_FETCH = 13'h0002;
    localparam logic [12:0] V_HALT  = 13'h0001;

    logic          Clk;
    logic          Reset_n;
    logic          Start;
    logic [IW-1:0] Instruction;
    logic          Instr_valid;
    logic          ZERO;
    logic          MEM_READ, MEM_WRITE, REG_WRITE, ACC_WRITE, IS_MEM;
    logic [2:0]    lookup;
    logic          branch, branch_taken, pc_advance, busy, done;
`ifdef CTRL_INSTR_COUNT_EN
    logic [15:0]   instr_count;
`endif

    int            n_checks;
    int            n_errors;
    logic [12:0]   sb_q[$];
    logic [15:0]   exp_cnt;
    logic [12:0]   obs;

    multicycle_ctrl #(.IW(IW), .MEM_LAT(MEM_LAT)) dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .Start        (Start),
        .Instruction  (Instruction),
        .Instr_valid  (Instr_valid),
        .ZERO         (ZERO),
        .MEM_READ     (MEM_READ),
        .MEM_WRITE    (MEM_WRITE),
        .REG_WRITE    (REG_WRITE),
        .ACC_WRITE    (ACC_WRITE),
        .IS_MEM       (IS_MEM),
        .lookup       (lookup),
        .branch       (branch),
        .branch_taken (branch_taken),
        .pc_advance   (pc_advance),
        .busy         (busy),
        .done         (done)
`ifdef CTRL_INSTR_COUNT_EN
        ,
        .instr_count  (instr_count)
`endif
    );

    assign obs = {MEM_READ, MEM_WRITE, REG_WRITE, ACC_WRITE, IS_MEM,
                  lookup, branch, branch_taken, pc_advance, busy, done};

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [15:0] got,
                             input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [12:0] exp_exec(input logic [8:0] ir, input logic z);
        logic [3:0]  op;
        logic [12:0] v;
        op = ir[7:4];
        v  = V_FETCH;
        if (ir[8]) begin
            v[4] = 1'b1;
            v[3] = z;
        end else begin
            case (op)
                4'd0, 4'd1, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd10, 4'd15:
                    v[9] = 1'b1;
                4'd2:  begin v[7:5] = 3'b100; v[4] = 1'b1; v[3] = 1'b1; end
                4'd3:  begin v[7:5] = 3'b010; v[4] = 1'b1; v[3] = 1'b1; end
                4'd9:  v[10] = 1'b1;
                4'd14: begin v[7:5] = 3'b001; v[9] = 1'b1; end
                default: ;
            endcase
        end
        if (op != 4'd13) v[2] = 1'b1;
        return v;
    endfunction

    // Drives one instruction from FETCH and checks every cycle until the
    // controller is back in FETCH (or reaches HALT).
    task automatic run_instr(input logic [8:0] ir, input logic z, input logic st);
        logic [3:0]  op;
        logic [12:0] e;
        string       tag;
        op  = ir[7:4];
        tag = $sformatf("instr_%h_z%0d", ir, z);
        Instruction = ir;
        Instr_valid = 1'b1;
        ZERO        = z;
        Start       = st;
        if (!ir[8] && (op == 4'd11 || op == 4'd12)) begin
            for (int k = 1; k <= MEM_LAT; k++) begin
                e = (op == 4'd11) ? 13'h1102 : 13'h0802;
                if (k == MEM_LAT) e = e | 13'h0004 | ((op == 4'd11) ? 13'h0200 : 13'h0000);
                sb_q.push_back(e);
            end
            sb_q.push_back(V_FETCH);
        end else begin
            sb_q.push_back(exp_exec(ir, z));
            sb_q.push_back((op == 4'd13) ? V_HALT : V_FETCH);
        end
        if (op != 4'd13) exp_cnt++;
        tick();
        Instr_valid = 1'b0;
        Instruction = 9'($urandom);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val(tag, {3'b000, obs}, {3'b000, e});
            if (sb_q.size() > 0) tick();
        end
        Start = 1'b0;
`ifdef CTRL_INSTR_COUNT_EN
        check_val("instr_count", instr_count, exp_cnt);
`endif
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        exp_cnt     = 16'h0000;
        Reset_n     = 1'b0;
        Start       = 1'b0;
        Instruction = '0;
        Instr_valid = 1'b0;
        ZERO        = 1'b0;

        #12;
        check_val("reset_outputs", {3'b000, obs}, {3'b000, V_IDLE});
`ifdef CTRL_INSTR_COUNT_EN
        check_val("reset_count", instr_count, 16'h0000);
`endif
        #11 Reset_n = 1'b1;

        Instr_valid = 1'b1;
        Instruction = 9'h090;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("idle_hold", {3'b000, obs}, {3'b000, V_IDLE});
        end
        Instr_valid = 1'b0;

        Start = 1'b1;
        tick();
        Start = 1'b0;
        check_val("start_to_fetch", {3'b000, obs}, {3'b000, V_FETCH});

        run_instr(9'h090, 1'b0, 1'b0);
        run_instr(9'h0B3, 1'b0, 1'b1);
        run_instr(9'h105, 1'b1, 1'b0);
        run_instr(9'h105, 1'b0, 1'b0);
        run_instr(9'h020, 1'b0, 1'b1);
        run_instr(9'h035, 1'b0, 1'b0);
        run_instr(9'h0E7, 1'b1, 1'b0);
        run_instr(9'h000, 1'b0, 1'b0);
        run_instr(9'h0F1, 1'b0, 1'b0);
        run_instr(9'h0C1, 1'b0, 1'b0);
        run_instr(9'h1B0, 1'b1, 1'b0);

        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("fetch_stall", {3'b000, obs}, {3'b000, V_FETCH});
        end

        run_instr(9'h0D0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check_val("halt_hold", {3'b000, obs}, {3'b000, V_HALT});
        end
        Start = 1'b1;
        tick();
        Start = 1'b0;
        check_val("halt_restart", {3'b000, obs}, {3'b000, V_FETCH});

        // Reset asserted during the second MEM cycle of a store
        Instruction = 9'h0C1;
        Instr_valid = 1'b1;
        tick();
        Instr_valid = 1'b0;
        check_val("store_mem1", {3'b000, obs}, 16'h0802);
        tick();
        check_val("store_mem2", {3'b000, obs}, 16'h0802);
        #2 Reset_n = 1'b0;
        #1;
        check_val("reset_mid_mem", {3'b000, obs}, {3'b000, V_IDLE});
        exp_cnt = 16'h0000;
        #3 Reset_n = 1'b1;
        Instr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("post_reset_idle", {3'b000, obs}, {3'b000, V_IDLE});
        end
        Instr_valid = 1'b0;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        check_val("post_reset_start", {3'b000, obs}, {3'b000, V_FETCH});

        run_instr(9'h090, 1'b0, 1'b0);
        run_instr(9'h0D0, 1'b0, 1'b0);
        tick();
        #2 Reset_n = 1'b0;
        #1;
        check_val("reset_mid_halt", {3'b000, obs}, {3'b000, V_IDLE});
        exp_cnt = 16'h0000;
`ifdef CTRL_INSTR_COUNT_EN
        check_val("reset_mid_halt_count", instr_count, exp_cnt);
`endif
        #3 Reset_n = 1'b1;
        tick();
        check_val("idle_after_halt_reset", {3'b000, obs}, {3'b000, V_IDLE});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
